// File: rtl/spi_slave_rx_tx_if.sv
// SPI pin group plus the command/read-data bus shared with the single-port RAM.
// Latency: none, wiring only.
// Backpressure: none; rx_valid and tx_valid are single-cycle strobes.
`timescale 1ns/1ps
interface spi_slave_rx_tx_if #(
  parameter int RX_W = 10,
  parameter int TX_W = 8
);
  logic            SS_n;
  logic            MOSI;
  logic            MISO;
  logic [RX_W-1:0] rx_data;
  logic            rx_valid;
  logic [TX_W-1:0] tx_data;
  logic            tx_valid;

  // Seen from the serial front end.
  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  // Seen from the SPI master and the RAM side together.
  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_rx_tx.sv
// SPI slave: deserialises MOSI frames into RX_W-bit RAM commands and serialises read-data replies onto MISO.
// Latency: rx_valid on the 12th sampled edge of a frame; the first MISO bit is on the edge that samples tx_valid.
// Backpressure: none; SS_n high aborts at once, and the read-data reply waits indefinitely for tx_valid.
`timescale 1ns/1ps
module spi_slave_rx_tx #(
  parameter int RX_W = 10,
  parameter int TX_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_slave_rx_tx_if.slave  bus
);

  localparam int CNT_W = $clog2(RX_W + 1);
  localparam int TXC_W = $clog2(TX_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(RX_W - 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(RX_W);
  localparam logic [TXC_W-1:0] TX_LAST  = TXC_W'(TX_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [RX_W-2:0]  rx_sr;      // the final bit goes straight into rx_word
  logic [RX_W-1:0]  rx_word;
  logic             rx_strobe;
  logic [TX_W-1:0]  tx_sr;      // reply bits still to be sent, MSB next
  logic [TXC_W-1:0] tx_cnt;
  logic             tx_busy;
  logic             tx_done;    // at most one reply per read-data frame
  logic             rd_addr_seen;
  logic             miso;
  logic             shift_state;

  assign shift_state = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: the select bit and rd_addr_seen choose the frame type; SS_n high returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!bus.SS_n) state_nxt = CHK_CMD;
      end
      CHK_CMD: begin
        if (bus.SS_n)          state_nxt = IDLE;
        else if (!bus.MOSI)    state_nxt = WRITE;
        else if (!rd_addr_seen) state_nxt = READ_ADD;
        else                   state_nxt = READ_DATA;
      end
      default: begin
        if (bus.SS_n) state_nxt = IDLE;
      end
    endcase
  end

  // Shift-in of the command word, then the MISO reply in READ_DATA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt      <= '0;
      rx_sr        <= '0;
      rx_word      <= '0;
      rx_strobe    <= 1'b0;
      tx_sr        <= '0;
      tx_cnt       <= '0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
      rd_addr_seen <= 1'b0;
      miso         <= 1'b0;
    end else begin
      rx_strobe <= 1'b0;
      if (!shift_state || bus.SS_n) begin
        // Outside a frame, or aborting one: partial words and replies are dropped.
        bit_cnt <= '0;
        tx_cnt  <= '0;
        tx_busy <= 1'b0;
        tx_done <= 1'b0;
        miso    <= 1'b0;
      end else if (bit_cnt != FULL) begin
        rx_sr   <= {rx_sr[RX_W-3:0], bus.MOSI};
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt == LAST_BIT) begin
          rx_word   <= {rx_sr, bus.MOSI};
          rx_strobe <= 1'b1;
          if (state == READ_ADD) rd_addr_seen <= 1'b1;
        end
      end else if (state == READ_DATA && !tx_done) begin
        if (tx_busy) begin
          if (tx_cnt == TX_LAST) begin
            miso         <= 1'b0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b1;
            rd_addr_seen <= 1'b0;
          end else begin
            miso   <= tx_sr[TX_W-1];
            tx_sr  <= {tx_sr[TX_W-2:0], 1'b0};
            tx_cnt <= tx_cnt + 1'b1;
          end
        end else if (bus.tx_valid) begin
          // The MSB goes out on the same edge that captures the RAM data.
          miso    <= bus.tx_data[TX_W-1];
          tx_sr   <= {bus.tx_data[TX_W-2:0], 1'b0};
          tx_cnt  <= '0;
          tx_busy <= 1'b1;
        end
      end
    end
  end

  assign bus.MISO     = miso;
  assign bus.rx_data  = rx_word;
  assign bus.rx_valid = rx_strobe;

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
`timescale 1ns/1ps
module tb_spi_slave_rx_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_rx_tx_if #(.RX_W(10), .TX_W(8)) bus();

  spi_slave_rx_tx #(.RX_W(10), .TX_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Monitor state, updated once per sampled cycle.
  int         tick_no = 0;
  int         rv_cnt  = 0;
  int         rv_tick = 0;
  int         miso_hi = 0;
  logic [9:0] rv_last = '0;
  int         e11_tick = 0;
  logic [7:0] miso_cap;
  int         pre_hi;

  // Frame-level reference model.
  bit         m_rd_seen = 1'b0;
  logic [9:0] m_rx_data = '0;

  task automatic tick();
    @(posedge clk);
    #1;
    tick_no++;
    if (bus.rx_valid === 1'b1) begin
      rv_cnt++;
      rv_tick = tick_no;
      rv_last = bus.rx_data;
    end
    if (bus.MISO !== 1'b0) miso_hi++;
  endtask

  task automatic send_frame(input bit sel, input logic [9:0] bits, input int nbits, input int extra);
    bus.SS_n = 1'b0;
    bus.MOSI = 1'($urandom);
    tick();
    bus.MOSI = sel;
    tick();
    for (int i = 0; i < nbits; i++) begin
      bus.MOSI = bits[9-i];
      tick();
    end
    e11_tick = tick_no;
    for (int i = 0; i < extra; i++) begin
      bus.MOSI = 1'($urandom);
      tick();
    end
  endtask

  task automatic end_frame();
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    tick();
  endtask

  task automatic do_reply(input logic [7:0] d, input int wait_cyc, input int nobs);
    int h0;
    miso_cap = '0;
    h0 = miso_hi;
    for (int i = 0; i < wait_cyc; i++) tick();
    pre_hi = miso_hi - h0;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    tick();
    miso_cap = {miso_cap[6:0], bus.MISO};
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'($urandom);
    for (int i = 1; i < nobs; i++) begin
      tick();
      miso_cap = {miso_cap[6:0], bus.MISO};
    end
  endtask

  task automatic test_reset();
    bus.SS_n = 1'b1; bus.MOSI = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = '0;
    rst_n = 1'b0;
    #3;
    checks++; if (bus.MISO !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", bus.MISO); end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", bus.rx_valid); end
    checks++; if (bus.rx_data !== 10'h000) begin errors++; $display("FAIL reset_rx_data got %h want 000", bus.rx_data); end
    checks++; if (dut.rd_addr_seen !== 1'b0) begin errors++; $display("FAIL reset_rd_addr_seen got %b want 0", dut.rd_addr_seen); end
    #19 rst_n = 1'b1;
    tick(); tick();
    checks++; if (bus.MISO !== 1'b0 || bus.rx_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle got miso=%b rxv=%b want 0 0", bus.MISO, bus.rx_valid); end
  endtask

  task automatic test_write_addr();
    int rv0 = rv_cnt;
    int mh0 = miso_hi;
    send_frame(1'b0, 10'h0A5, 10, 0);
    checks++; if (rv_cnt - rv0 != 1) begin errors++; $display("FAIL wa_pulses got %0d want 1", rv_cnt - rv0); end
    checks++; if (rv_tick != e11_tick) begin errors++; $display("FAIL wa_pulse_edge got %0d want %0d", rv_tick, e11_tick); end
    checks++; if (rv_last !== 10'h0A5) begin errors++; $display("FAIL wa_rx_data got %h want 0a5", rv_last); end
    end_frame();
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL wa_pulse_end got %b want 0", bus.rx_valid); end
    checks++; if (bus.rx_data !== 10'h0A5) begin errors++; $display("FAIL wa_hold got %h want 0a5", bus.rx_data); end
    checks++; if (miso_hi != mh0) begin errors++; $display("FAIL wa_miso got %0d high cycles want 0", miso_hi - mh0); end
    m_rx_data = 10'h0A5;
  endtask

  task automatic test_write_data();
    int rv0 = rv_cnt;
    send_frame(1'b0, 10'h13C, 10, 3);
    end_frame();
    checks++; if (rv_cnt - rv0 != 1) begin errors++; $display("FAIL wd_pulses got %0d want 1", rv_cnt - rv0); end
    checks++; if (rv_last !== 10'h13C || bus.rx_data !== 10'h13C) begin errors++; $display("FAIL wd_rx_data got %h/%h want 13c", rv_last, bus.rx_data); end
    m_rx_data = 10'h13C;
  endtask

  task automatic test_read_seq();
    send_frame(1'b1, 10'h2A5, 10, 0);
    checks++; if (rv_last !== 10'h2A5) begin errors++; $display("FAIL ra_rx_data got %h want 2a5", rv_last); end
    checks++; if (dut.rd_addr_seen !== 1'b1) begin errors++; $display("FAIL ra_seen got %b want 1", dut.rd_addr_seen); end
    end_frame();
    send_frame(1'b1, 10'h300, 10, 0);
    checks++; if (rv_last !== 10'h300) begin errors++; $display("FAIL rd_rx_data got %h want 300", rv_last); end
    do_reply(8'hC3, 1, 8);
    checks++; if (pre_hi != 0) begin errors++; $display("FAIL rd_pre_miso got %0d high cycles want 0", pre_hi); end
    checks++; if (miso_cap !== 8'hC3) begin errors++; $display("FAIL rd_miso_bits got %h want c3", miso_cap); end
    tick();
    checks++; if (bus.MISO !== 1'b0) begin errors++; $display("FAIL rd_miso_tail got %b want 0", bus.MISO); end
    checks++; if (dut.rd_addr_seen !== 1'b0) begin errors++; $display("FAIL rd_seen_clear got %b want 0", dut.rd_addr_seen); end
    end_frame();
    m_rx_data = 10'h300;
    m_rd_seen = 1'b0;
  endtask

  task automatic test_abort();
    int rv0 = rv_cnt;
    logic [9:0] r = 10'($urandom);
    send_frame(1'b0, 10'h3FF, 6, 0);
    end_frame();
    checks++; if (rv_cnt != rv0) begin errors++; $display("FAIL ab_pulses got %0d want 0", rv_cnt - rv0); end
    checks++; if (bus.rx_data !== m_rx_data) begin errors++; $display("FAIL ab_hold got %h want %h", bus.rx_data, m_rx_data); end
    send_frame(1'b0, r, 10, 0);
    end_frame();
    checks++; if (rv_last !== r || rv_cnt - rv0 != 1) begin errors++; $display("FAIL ab_next got %h (%0d pulses) want %h (1)", rv_last, rv_cnt - rv0, r); end
    checks++; if (dut.rd_addr_seen !== m_rd_seen) begin errors++; $display("FAIL ab_seen got %b want %b", dut.rd_addr_seen, m_rd_seen); end
    m_rx_data = r;
  endtask

  task automatic test_async_reset();
    logic [9:0] r = 10'($urandom);
    send_frame(1'b1, 10'h2A5, 10, 0);
    end_frame();
    send_frame(1'b1, 10'h3C7, 10, 0);
    do_reply(8'hE5, 0, 3);
    checks++; if (miso_cap[2:0] !== 3'b111 || bus.MISO !== 1'b1) begin errors++; $display("FAIL ar_pre got %b/%b want 111/1", miso_cap[2:0], bus.MISO); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.MISO !== 1'b0) begin errors++; $display("FAIL ar_miso got %b want 0", bus.MISO); end
    checks++; if (bus.rx_data !== 10'h000 || bus.rx_valid !== 1'b0) begin errors++; $display("FAIL ar_rx got %h/%b want 000/0", bus.rx_data, bus.rx_valid); end
    checks++; if (dut.rd_addr_seen !== 1'b0) begin errors++; $display("FAIL ar_seen got %b want 0", dut.rd_addr_seen); end
    bus.SS_n = 1'b1;
    #10 rst_n = 1'b1;
    m_rd_seen = 1'b0;
    m_rx_data = '0;
    tick();
    send_frame(1'b1, r, 10, 0);
    checks++; if (rv_last !== r) begin errors++; $display("FAIL ar_next_rx got %h want %h", rv_last, r); end
    checks++; if (dut.rd_addr_seen !== 1'b1) begin errors++; $display("FAIL ar_next_read_add got %b want 1", dut.rd_addr_seen); end
    do_reply(8'hFF, 0, 8);
    checks++; if (miso_cap !== 8'h00) begin errors++; $display("FAIL ar_read_add_miso got %h want 00", miso_cap); end
    end_frame();
    m_rx_data = r;
    m_rd_seen = 1'b1;
  endtask

  task automatic test_spurious();
    int mh0 = miso_hi;
    int rv0 = rv_cnt;
    logic [9:0] r = 10'($urandom);
    bus.tx_data  = 8'hFF;
    bus.tx_valid = 1'b1;
    tick(); tick(); tick();
    send_frame(1'b0, r, 10, 2);
    end_frame();
    bus.tx_valid = 1'b0;
    checks++; if (miso_hi != mh0) begin errors++; $display("FAIL sp_miso got %0d high cycles want 0", miso_hi - mh0); end
    checks++; if (rv_last !== r || rv_cnt - rv0 != 1) begin errors++; $display("FAIL sp_rx got %h (%0d) want %h (1)", rv_last, rv_cnt - rv0, r); end
    checks++; if (dut.rd_addr_seen !== m_rd_seen) begin errors++; $display("FAIL sp_seen got %b want %b", dut.rd_addr_seen, m_rd_seen); end
    m_rx_data = r;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      bit         sel   = 1'($urandom_range(0, 1));
      logic [9:0] data  = 10'($urandom);
      bit         abort = ($urandom_range(0, 4) == 0);
      int         nb    = abort ? int'($urandom_range(0, 9)) : 10;
      int         extra = abort ? 0 : int'($urandom_range(0, 3));
      bit         rd    = sel && m_rd_seen;
      int         rv0   = rv_cnt;
      int         mh0   = miso_hi;
      send_frame(sel, data, nb, extra);
      if (!abort) begin
        checks++; if (rv_cnt - rv0 != 1 || rv_last !== data) begin errors++; $display("FAIL rnd%0d_rx got %h (%0d) want %h (1)", n, rv_last, rv_cnt - rv0, data); end
        m_rx_data = data;
        if (sel && !m_rd_seen) m_rd_seen = 1'b1;
      end else begin
        checks++; if (rv_cnt != rv0) begin errors++; $display("FAIL rnd%0d_abort got %0d pulses want 0", n, rv_cnt - rv0); end
      end
      if (!abort && rd) begin
        logic [7:0] d     = 8'($urandom);
        int         w     = int'($urandom_range(0, 4));
        bit         trunc = ($urandom_range(0, 3) == 0);
        int         nobs  = trunc ? int'($urandom_range(1, 7)) : 8;
        do_reply(d, w, nobs);
        checks++; if (miso_cap !== (d >> (8 - nobs))) begin errors++; $display("FAIL rnd%0d_miso got %h want %h", n, miso_cap, d >> (8 - nobs)); end
        if (!trunc) begin
          tick();
          checks++; if (bus.MISO !== 1'b0) begin errors++; $display("FAIL rnd%0d_tail got %b want 0", n, bus.MISO); end
          m_rd_seen = 1'b0;
        end
      end else begin
        checks++; if (miso_hi != mh0) begin errors++; $display("FAIL rnd%0d_quiet got %0d high cycles want 0", n, miso_hi - mh0); end
      end
      end_frame();
      checks++; if (bus.MISO !== 1'b0 || bus.rx_data !== m_rx_data) begin errors++; $display("FAIL rnd%0d_end got %b/%h want 0/%h", n, bus.MISO, bus.rx_data, m_rx_data); end
      checks++; if (dut.rd_addr_seen !== m_rd_seen) begin errors++; $display("FAIL rnd%0d_seen got %b want %b", n, dut.rd_addr_seen, m_rd_seen); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_addr();
    test_write_data();
    test_read_seq();
    test_abort();
    test_async_reset();
    test_spurious();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
